fetch_unit: RTL and testbench

Fetch stage of the five-stage MIPS pipeline, directly downstream of the next-PC selector. Holds the fetch PC register (PCF), issues one instruction request at a time on the instruction bus, and presents the fetched word to decode. Generates PCPlus4F back to the selector, and a stall request to the hazard unit while a fetch is outstanding. Handles exception/eret redirects that arrive mid-fetch by discarding the stale response.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: bus bundles, fetch FSM states, reset PC.
// Used by fetch_unit and its bench.
package fetch_unit_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      logic  valid;
      addr_t addr;
   } ibus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } ibus_resp_t;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP_REQ,
      S_DROP_WAIT
   } fetch_state_t;

   localparam addr_t PC_RESET = 32'hbfc00000;

endpackage

// File: rtl/fetch_unit.sv
// MIPS fetch stage: PCF register, single-outstanding ibus fetch, redirect drop.
// Optional FETCH_ALIGN_CHECK_EN raises AdELF on a misaligned PCF.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter addr_t RESET_PC = PC_RESET
) (
   input  logic       clk,
   input  logic       resetn,
   input  addr_t      PC0,
   input  logic       RedirectF,
   input  logic       StallF,
   output ibus_req_t  ireq,
   input  ibus_resp_t iresp,
   output addr_t      PCF,
   output addr_t      PCPlus4F,
   output word_t      InstrF,
   output logic       InstrValidF,
   output logic       FetchBusy,
   output logic       AdELF
);

   fetch_state_t r_state;
   fetch_state_t w_state_nx;
   addr_t        r_pcf;
   addr_t        w_pcf_nx;
   addr_t        r_req_addr;
   addr_t        w_req_nx;
   word_t        r_instr;
   word_t        w_instr_nx;
   logic         w_adel;
   logic         w_done;
   logic         w_valid;
   logic         w_ivalid;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_adel = (r_state == S_REQ) && (r_pcf[1:0] != 2'b00);
`else
   assign w_adel = 1'b0;
`endif

   // Next-state, next-PC and output decode
   always_comb begin
      w_state_nx = r_state;
      w_pcf_nx   = r_pcf;
      w_req_nx   = r_req_addr;
      w_instr_nx = r_instr;
      w_done     = 1'b0;
      w_valid    = 1'b0;
      w_ivalid   = 1'b0;
      InstrF     = '0;
      unique case (r_state)
         S_REQ: begin
            if (w_adel) begin
               w_ivalid   = 1'b1;
               w_done     = 1'b1;
               w_instr_nx = '0;
            end else begin
               w_valid = 1'b1;
               if (iresp.addr_ok) w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (iresp.data_ok) begin
               w_ivalid   = 1'b1;
               InstrF     = iresp.data;
               w_instr_nx = iresp.data;
               w_done     = 1'b1;
            end
         end
         S_HOLD: begin
            w_ivalid = 1'b1;
            InstrF   = r_instr;
            w_done   = 1'b1;
         end
         S_DROP_REQ: begin
            w_valid = 1'b1;
            if (iresp.addr_ok) w_state_nx = S_DROP_WAIT;
         end
         S_DROP_WAIT: begin
            if (iresp.data_ok) begin
               w_state_nx = S_REQ;
               w_req_nx   = RedirectF ? PC0 : r_pcf;
            end
         end
         default: w_state_nx = S_REQ;
      endcase
      if (w_done) begin
         if (RedirectF || !StallF) begin
            w_state_nx = S_REQ;
            w_pcf_nx   = PC0;
            w_req_nx   = PC0;
         end else begin
            w_state_nx = S_HOLD;
         end
      end else if (RedirectF) begin
         w_pcf_nx = PC0;
         if (r_state == S_REQ)
            w_state_nx = iresp.addr_ok ? S_DROP_WAIT : S_DROP_REQ;
         else if (r_state == S_WAIT)
            w_state_nx = S_DROP_WAIT;
      end
   end

   assign ireq.valid  = w_valid & resetn;
   assign ireq.addr   = r_req_addr;
   assign InstrValidF = w_ivalid;
   assign FetchBusy   = ~w_ivalid;
   assign AdELF       = w_adel & resetn;
   assign PCF         = r_pcf;
   assign PCPlus4F    = r_pcf + 32'd4;

   // State, fetch PC, request address and instruction latch
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_REQ;
         r_pcf      <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_instr    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_pcf      <= w_pcf_nx;
         r_req_addr <= w_req_nx;
         r_instr    <= w_instr_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: normal, stall, slow bus, redirects, reset.
// Build with FETCH_ALIGN_CHECK_EN to exercise the misaligned-PC path.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic       clk = 1'b0;
   logic       resetn;
   addr_t      PC0;
   logic       RedirectF;
   logic       StallF;
   ibus_req_t  ireq;
   ibus_resp_t iresp;
   addr_t      PCF;
   addr_t      PCPlus4F;
   word_t      InstrF;
   logic       InstrValidF;
   logic       FetchBusy;
   logic       AdELF;

   typedef struct {
      addr_t pc;
      word_t ins;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   fetch_unit dut (
      .clk         (clk),
      .resetn      (resetn),
      .PC0         (PC0),
      .RedirectF   (RedirectF),
      .StallF      (StallF),
      .ireq        (ireq),
      .iresp       (iresp),
      .PCF         (PCF),
      .PCPlus4F    (PCPlus4F),
      .InstrF      (InstrF),
      .InstrValidF (InstrValidF),
      .FetchBusy   (FetchBusy),
      .AdELF       (AdELF)
   );

   always #5 clk = ~clk;

   function automatic word_t memw(addr_t a);
      return 32'h24020001 + (a - PC_RESET);
   endfunction

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push(addr_t pc, word_t ins);
      exp_t e;
      e.pc  = pc;
      e.ins = ins;
      sb.push_back(e);
   endtask

   // Start of a new cycle with the bus and control inputs idle
   task automatic cyc();
      @(posedge clk);
      #1;
      iresp     = '0;
      StallF    = 1'b0;
      RedirectF = 1'b0;
   endtask

   // Decode-side scoreboard: every valid instruction must be expected
   always @(negedge clk) begin
      if (resetn && InstrValidF) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            chk("sb_instr", InstrF, sb[0].ins);
            chk("sb_pcf", PCF, sb[0].pc);
            if (!StallF || RedirectF) void'(sb.pop_front());
         end
      end
   end

   task automatic fetch(addr_t pc, addr_t nxt, int adly, int stl);
      for (int i = 0; i < adly; i++) begin
         cyc();
         #3;
         chk("wait_valid", 32'(ireq.valid), 32'd1);
         chk("wait_addr", ireq.addr, pc);
         chk("wait_busy", 32'(FetchBusy), 32'd1);
      end
      cyc();
      iresp.addr_ok = 1'b1;
      #3;
      chk("req_pcf", PCF, pc);
      chk("req_valid", 32'(ireq.valid), 32'd1);
      chk("req_addr", ireq.addr, pc);
      chk("req_pc4", PCPlus4F, pc + 32'd4);
      cyc();
      iresp.data_ok = 1'b1;
      iresp.data    = memw(pc);
      PC0           = nxt;
      StallF        = (stl > 0);
      push(pc, memw(pc));
      #3;
      chk("done_busy", 32'(FetchBusy), 32'd0);
      chk("done_noreq", 32'(ireq.valid), 32'd0);
      if (stl > 0) begin
         for (int i = 1; i < stl; i++) begin
            cyc();
            StallF = 1'b1;
            #3;
            chk("hold_pcf", PCF, pc);
            chk("hold_valid", 32'(InstrValidF), 32'd1);
         end
         cyc();
         #3;
         chk("hold_go", 32'(InstrValidF), 32'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      PC0       = '0;
      RedirectF = 1'b0;
      StallF    = 1'b0;
      iresp     = '0;
      repeat (3) @(posedge clk);
      #4;
      chk("rst_valid", 32'(ireq.valid), 32'd0);
      chk("rst_pcf", PCF, PC_RESET);
      chk("rst_ivalid", 32'(InstrValidF), 32'd0);
      chk("rst_instr", InstrF, 32'd0);
      chk("rst_adel", 32'(AdELF), 32'd0);
      chk("rst_busy", 32'(FetchBusy), 32'd1);
      cyc();
      resetn = 1'b1;
      #3;
      chk("first_valid", 32'(ireq.valid), 32'd1);
      chk("first_addr", ireq.addr, 32'hbfc00000);

      fetch(32'hbfc00000, 32'hbfc00004, 0, 0);
      fetch(32'hbfc00004, 32'hbfc00008, 0, 3);
      fetch(32'hbfc00008, 32'hbfc0000c, 4, 0);

      // Redirect while waiting for data
      cyc();
      iresp.addr_ok = 1'b1;
      #3;
      chk("rw_addr", ireq.addr, 32'hbfc0000c);
      cyc();
      RedirectF = 1'b1;
      PC0       = 32'hbfc00380;
      #3;
      chk("rw_ivalid", 32'(InstrValidF), 32'd0);
      cyc();
      iresp.data_ok = 1'b1;
      iresp.data    = 32'hdeadbeef;
      #3;
      chk("rw_pcf", PCF, 32'hbfc00380);
      chk("rw_drop", 32'(InstrValidF), 32'd0);
      chk("rw_busy", 32'(FetchBusy), 32'd1);
      fetch(32'hbfc00380, 32'hbfc00384, 0, 0);

      // Redirect before the request is accepted
      cyc();
      RedirectF = 1'b1;
      PC0       = 32'hbfc00500;
      #3;
      chk("rr_addr0", ireq.addr, 32'hbfc00384);
      cyc();
      #3;
      chk("rr_valid", 32'(ireq.valid), 32'd1);
      chk("rr_addr1", ireq.addr, 32'hbfc00384);
      chk("rr_pcf", PCF, 32'hbfc00500);
      cyc();
      iresp.addr_ok = 1'b1;
      #3;
      chk("rr_addr2", ireq.addr, 32'hbfc00384);
      cyc();
      iresp.data_ok = 1'b1;
      iresp.data    = 32'hdeadbeef;
      #3;
      chk("rr_drop", 32'(InstrValidF), 32'd0);
      chk("rr_noreq", 32'(ireq.valid), 32'd0);
      fetch(32'hbfc00500, 32'hbfc00002, 0, 0);

`ifdef FETCH_ALIGN_CHECK_EN
      cyc();
      PC0 = 32'hbfc00600;
      push(32'hbfc00002, 32'd0);
      #3;
      chk("al_adel", 32'(AdELF), 32'd1);
      chk("al_noreq", 32'(ireq.valid), 32'd0);
      chk("al_ivalid", 32'(InstrValidF), 32'd1);
      chk("al_instr", InstrF, 32'd0);
`else
      cyc();
      #3;
      chk("al_adel", 32'(AdELF), 32'd0);
      chk("al_addr", ireq.addr, 32'hbfc00002);
      fetch(32'hbfc00002, 32'hbfc00600, 0, 0);
`endif
      fetch(32'hbfc00600, 32'hbfc00604, 0, 0);

      // Reset in the middle of a fetch
      cyc();
      iresp.addr_ok = 1'b1;
      #3;
      cyc();
      resetn = 1'b0;
      sb.delete();
      #3;
      chk("mr_pcf", PCF, PC_RESET);
      chk("mr_valid", 32'(ireq.valid), 32'd0);
      chk("mr_ivalid", 32'(InstrValidF), 32'd0);
      cyc();
      resetn = 1'b1;
      #3;
      chk("mr_addr", ireq.addr, PC_RESET);
      chk("mr_req", 32'(ireq.valid), 32'd1);
      fetch(32'hbfc00000, 32'hbfc00004, 0, 0);

      cyc();
      #3;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
